// File: rtl/pic_fetch_sequencer.sv
// pic_fetch_sequencer: fetch FSM owning the PC, ROM handshake, instruction issue,
// GOTO/CALL/RETLW/skip resolution and a circular return-address stack.
module pic_fetch_sequencer #(
  parameter int         ROM_WAIT    = 3,
  parameter int         STACK_DEPTH = 2,
  parameter logic [9:0] RESET_VEC   = 10'h000
) (
  input  logic        ck,
  input  logic        clr,
  input  logic        run,
  output logic [9:0]  rom_addr,
  output logic        rom_oe,
  input  logic [11:0] rom_data,
  output logic [11:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        ex_skip,
  output logic [9:0]  pc,
  output logic        busy,
  output logic        stk_ovf,
  output logic        stk_unf
);
  localparam int SW = $clog2(STACK_DEPTH);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, LATCH, ISSUE} state_t;
  state_t        state;
  logic [3:0]    cnt;
  logic [SW-1:0] sp, sp_m1;
  logic [SW:0]   occ;
  logic [9:0]    stk [STACK_DEPTH];
  logic [9:0]    next_pc;
  logic          is_goto, is_call, is_ret, full;
  assign is_goto  = ir[11:9] == 3'b101;
  assign is_call  = ir[11:8] == 4'b1001;
  assign is_ret   = ir[11:8] == 4'b1000;
  assign sp_m1    = sp - 1'b1;
  assign full     = occ == (SW+1)'(STACK_DEPTH);
  assign rom_addr = pc;
  assign busy     = state != IDLE;
  // {8'd0, ex_skip, ~ex_skip} is 2 when skipping, 1 otherwise
  assign next_pc  = is_goto ? {pc[9], ir[8:0]} :
                    is_call ? {pc[9], 1'b0, ir[7:0]} :
                    is_ret  ? stk[sp_m1] :
                              pc + {8'd0, ex_skip, ~ex_skip};
  always_ff @(posedge ck) begin
    if (clr) begin
      state    <= IDLE;
      pc       <= RESET_VEC;
      ir       <= '0;
      ir_valid <= 1'b0;
      rom_oe   <= 1'b0;
      sp       <= '0;
      occ      <= '0;
      cnt      <= '0;
      stk_ovf  <= 1'b0;
      stk_unf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (run) begin
          state  <= FETCH;
          rom_oe <= 1'b1;
        end
        FETCH: begin
          state <= ROM_WAIT == 0 ? LATCH : WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == 4'(ROM_WAIT - 1)) state <= LATCH;
        end
        LATCH: begin
          ir       <= rom_data;
          ir_valid <= 1'b1;
          rom_oe   <= 1'b0;
          state    <= ISSUE;
        end
        ISSUE: if (ir_ready) begin
          pc       <= next_pc;
          ir_valid <= 1'b0;
          rom_oe   <= run;
          state    <= run ? FETCH : IDLE;
          // a full stack overwrites its oldest entry, which sits at sp
          if (is_call) begin
            stk[sp] <= pc + 10'd1;
            sp      <= sp + 1'b1;
            if (full) stk_ovf <= 1'b1;
            else occ <= occ + 1'b1;
          end
          if (is_ret) begin
            sp <= sp_m1;
            if (occ == '0) stk_unf <= 1'b1;
            else occ <= occ - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pic_fetch_sequencer.sv
// tb_pic_fetch_sequencer: directed scenarios plus randomized run against an
// instruction-level reference model of PC flow, stack and issue timing.
module tb_pic_fetch_sequencer;
  localparam int ROM_WAIT = 3;
  localparam int DEPTH    = 2;
  logic        ck = 1'b0;
  logic        clr = 1'b1, run = 1'b0, ir_ready = 1'b1, ex_skip = 1'b0;
  logic [9:0]  rom_addr, pc;
  logic [11:0] rom_data, ir;
  logic        rom_oe, ir_valid, busy, stk_ovf, stk_unf;
  logic [11:0] rom [1024];
  int n_vec = 0, n_err = 0;
  int m_pc = 0, m_ld = -1, m_sp = 0, m_occ = 0;
  int m_stk [DEPTH];
  bit m_ovf = 0, m_unf = 0;

  pic_fetch_sequencer #(.ROM_WAIT(ROM_WAIT), .STACK_DEPTH(DEPTH), .RESET_VEC(10'h000)) dut (
    .ck(ck), .clr(clr), .run(run), .rom_addr(rom_addr), .rom_oe(rom_oe),
    .rom_data(rom_data), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ex_skip(ex_skip), .pc(pc), .busy(busy), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 ck = ~ck;
  assign rom_data = rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_ld = clock edges still to come before the instruction is
  // issued (0 = being issued, -1 = halted); PC/stack evolve per instruction.
  always @(negedge ck) begin
    int w, np;
    if (m_ld > 0) m_ld--;
    check("pc", pc, m_pc);
    check("rom_addr", rom_addr, m_pc);
    check("ir_valid", ir_valid, m_ld == 0);
    check("rom_oe", rom_oe, m_ld > 0);
    check("busy", busy, m_ld >= 0);
    check("stk_ovf", stk_ovf, m_ovf);
    check("stk_unf", stk_unf, m_unf);
    if (m_ld == 0) check("ir", ir, rom[m_pc]);
    if (clr) begin
      m_pc = 0; m_ld = -1; m_sp = 0; m_occ = 0; m_ovf = 0; m_unf = 0;
    end else if (m_ld == 0 && ir_ready) begin
      w = int'(rom[m_pc]);
      if ((w >> 9) == 5) np = (m_pc & 512) | (w & 511);
      else if ((w >> 8) == 9) begin
        m_stk[m_sp] = (m_pc + 1) % 1024;
        m_sp = (m_sp + 1) % DEPTH;
        if (m_occ == DEPTH) m_ovf = 1; else m_occ++;
        np = (m_pc & 512) | (w & 255);
      end else if ((w >> 8) == 8) begin
        m_sp = (m_sp + DEPTH - 1) % DEPTH;
        if (m_occ == 0) m_unf = 1; else m_occ--;
        np = m_stk[m_sp];
      end else np = (m_pc + (ex_skip ? 2 : 1)) % 1024;
      m_pc = np;
      m_ld = run ? ROM_WAIT + 3 : -1;
    end else if (m_ld < 0 && run) m_ld = ROM_WAIT + 3;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic restart();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic next_hs(output int n);
    n = 0;
    while (!ir_valid && n < 60) begin
      tick(1);
      n++;
    end
    if (!ir_valid) check("hs_timeout", 0, 1);
    else tick(1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      tick(1);
      n++;
    end
    check("idle", busy, 0);
  endtask

  initial begin
    int n;
    logic [11:0] ir_s;
    foreach (rom[i]) rom[i] = 12'h000;
    tick(2);
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_valid", ir_valid, 0);
    check("rst_oe", rom_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {stk_ovf, stk_unf}, 0);
    clr = 1'b0;
    // T1: sequential NOPs, 6-cycle cadence
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_hs(n);
      if (i > 0) check("period", n, ROM_WAIT + 2);
      check("t1_pc", pc, i + 1);
    end
    run = 1'b0;
    wait_idle();
    // T2: GOTO
    rom[0] = 12'hA55;
    restart();
    run = 1'b1;
    tick(1);
    run = 1'b0;
    next_hs(n);
    check("goto_addr", rom_addr, 10'h055);
    wait_idle();
    // T3: CALL then RETLW
    rom[0] = 12'h920; rom[10'h20] = 12'h800; rom[1] = 12'h000;
    restart();
    run = 1'b1;
    next_hs(n);
    check("call_addr", rom_addr, 10'h020);
    next_hs(n);
    check("ret_addr", rom_addr, 10'h001);
    check("t3_flags", {stk_ovf, stk_unf}, 0);
    run = 1'b0;
    next_hs(n);
    wait_idle();
    // T4: three nested CALLs overflow a 2-deep stack, three RETLWs underflow it
    rom[0] = 12'h910; rom[10'h10] = 12'h920; rom[10'h20] = 12'h930;
    rom[10'h30] = 12'h800; rom[10'h21] = 12'h800; rom[10'h11] = 12'h800;
    restart();
    run = 1'b1;
    for (int i = 0; i < 3; i++) next_hs(n);
    check("t4_ovf", stk_ovf, 1);
    check("t4_unf_pre", stk_unf, 0);
    for (int i = 0; i < 3; i++) next_hs(n);
    check("t4_unf", stk_unf, 1);
    check("t4_wrap_pc", pc, 10'h021);
    run = 1'b0;
    next_hs(n);
    wait_idle();
    // T5: PC wrap with and without skip
    foreach (rom[i]) rom[i] = 12'h000;
    restart();
    run = 1'b1;
    ex_skip = 1'b1;
    for (int i = 0; i < 511; i++) next_hs(n);
    check("t5_pc_3fe", pc, 10'h3FE);
    next_hs(n);
    check("t5_wrap_skip", pc, 10'h000);
    ex_skip = 1'b0;
    next_hs(n);
    ex_skip = 1'b1;
    for (int i = 0; i < 511; i++) next_hs(n);
    check("t5_pc_3ff", pc, 10'h3FF);
    ex_skip = 1'b0;
    next_hs(n);
    check("t5_wrap_noskip", pc, 10'h000);
    run = 1'b0;
    next_hs(n);
    wait_idle();
    // T6: stall, halt at handshake, reset during WAIT
    restart();
    run = 1'b1;
    ir_ready = 1'b0;
    n = 0;
    while (!ir_valid && n < 60) begin
      tick(1);
      n++;
    end
    ir_s = ir;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("stall_ir", ir, ir_s);
      check("stall_valid", ir_valid, 1);
    end
    run = 1'b0;
    ir_ready = 1'b1;
    tick(2);
    check("halt_busy", busy, 0);
    check("halt_oe", rom_oe, 0);
    check("halt_pc", pc, 1);
    run = 1'b1;
    tick(3);
    check("wait_oe", rom_oe, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    run = 1'b0;
    check("clr_pc", pc, 0);
    check("clr_valid", ir_valid, 0);
    check("clr_busy", busy, 0);
    // randomized program and handshake traffic
    foreach (rom[i]) begin
      n = $urandom_range(0, 9);
      rom[i] = n < 4 ? {1'b0, 11'($urandom)} :
               n < 6 ? {3'b101, 9'($urandom)} :
               n < 8 ? {4'b1001, 8'($urandom)} : {4'b1000, 8'($urandom)};
    end
    restart();
    for (int i = 0; i < 4000; i++) begin
      run      = ($urandom % 16) != 0;
      ir_ready = ($urandom % 4) != 0;
      ex_skip  = $urandom % 2;
      clr      = ($urandom % 300) == 0;
      tick(1);
    end
    clr = 1'b0;
    run = 1'b0;
    ir_ready = 1'b1;
    wait_idle();
    tick(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
